// File: rtl/snoopy_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter package
// Shared types and helpers for the snoopy bus arbiter:
//   ArbiterState : FSM encoding (IDLE while the bus is free, GRANTED while a
//                  CPU-side controller owns it).
//   oneHot()     : index to one-hot vector, MAX_CACHES bits wide; callers
//                  size-cast the result down to their own port width.
// -----------------------------------------------------------------------------
package arbiter;

   // Widest arbiter the helpers support; oneHot() indexes with INDEX_BITS.
   localparam int MAX_CACHES = 32;
   localparam int INDEX_BITS = 5;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } ArbiterState;

   function automatic logic [MAX_CACHES-1:0] oneHot(input logic [INDEX_BITS-1:0] index);
      logic [MAX_CACHES-1:0] result;
      result        = {MAX_CACHES{1'b0}};
      result[index] = 1'b1;
      return result;
   endfunction

endpackage

// File: rtl/snoopy_bus_arbiter_round_robin_select.sv
// -----------------------------------------------------------------------------
// round_robin_select
// Combinational search for the first set bit of a request vector, scanning
// upward from a start index and wrapping past the top. With startIndex tied
// to zero it degenerates to a fixed lowest-index-wins priority encoder.
// Ports:
//   requests   in  [WIDTH]       request vector
//   startIndex in  [INDEX_WIDTH] first position examined (must be < WIDTH)
//   found      out               any request set
//   index      out [INDEX_WIDTH] selected position (0 when found is low)
// -----------------------------------------------------------------------------
module round_robin_select #(
   parameter int WIDTH       = 4,
   parameter int INDEX_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]       requests,
   input  logic [INDEX_WIDTH-1:0] startIndex,
   output logic                   found,
   output logic [INDEX_WIDTH-1:0] index
);

   logic [INDEX_WIDTH-1:0] candidate_s;

   // Walk offsets from farthest to nearest so the nearest hit is the last write.
   always_comb begin
      found       = 1'b0;
      index       = {INDEX_WIDTH{1'b0}};
      candidate_s = {INDEX_WIDTH{1'b0}};
      for (int offset = WIDTH - 1; offset >= 0; offset--) begin
         candidate_s = INDEX_WIDTH'(((int'(startIndex) + offset) >= WIDTH)
                                    ? (int'(startIndex) + offset - WIDTH)
                                    : (int'(startIndex) + offset));
         found       = found | requests[candidate_s];
         index       = requests[candidate_s] ? candidate_s : index;
      end
   end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// -----------------------------------------------------------------------------
// snoopy_bus_arbiter
// Grants the shared snoopy bus to one CPU-side controller at a time
// (round-robin, the previous owner has lowest priority) and, while a CPU
// transaction is open, grants data-supply rights to at most one other
// cache's snoopy controller (fixed priority, lowest index wins).
// Ports:
//   clock           in               rising-edge clock
//   reset           in               synchronous, active-high
//   cpuRequests     in  [N]          CPU controller bus requests (held)
//   snoopyRequests  in  [N]          snoopy controller supply requests
//   cpuGrants       out [N]          one-hot or zero, registered
//   snoopyGrants    out [N]          one-hot or zero, registered, never the owner
//   busOwner        out [clog2(N)]   current CPU grantee, valid while busBusy
//   busBusy         out              high while cpuGrants is non-zero
// -----------------------------------------------------------------------------
module snoopy_bus_arbiter
   import arbiter::*;
#(
   parameter int NUMBER_OF_CACHES = 4
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUMBER_OF_CACHES-1:0]         cpuRequests,
   input  logic [NUMBER_OF_CACHES-1:0]         snoopyRequests,
   output logic [NUMBER_OF_CACHES-1:0]         cpuGrants,
   output logic [NUMBER_OF_CACHES-1:0]         snoopyGrants,
   output logic [$clog2(NUMBER_OF_CACHES)-1:0] busOwner,
   output logic                                busBusy
);

   localparam int OWNER_WIDTH = $clog2(NUMBER_OF_CACHES);
   localparam logic [OWNER_WIDTH-1:0] LAST_CACHE = OWNER_WIDTH'(NUMBER_OF_CACHES - 1);
   localparam logic [NUMBER_OF_CACHES-1:0] NO_GRANT = {NUMBER_OF_CACHES{1'b0}};

   ArbiterState                 state_r;
   logic [OWNER_WIDTH-1:0]      lastOwner_r;

   logic [OWNER_WIDTH-1:0]      cpuStart_s;
   logic                        cpuFound_s;
   logic [OWNER_WIDTH-1:0]      cpuSelect_s;
   logic [NUMBER_OF_CACHES-1:0] ownerMask_s;
   logic [NUMBER_OF_CACHES-1:0] snoopyEligible_s;
   logic                        snoopyFound_s;
   logic [OWNER_WIDTH-1:0]      snoopySelect_s;

   // CPU search starts one past the previous owner, wrapping at the top.
   assign cpuStart_s = (lastOwner_r == LAST_CACHE) ? {OWNER_WIDTH{1'b0}}
                                                   : lastOwner_r + OWNER_WIDTH'(1);

   // The bus owner never supplies data to its own transaction.
   assign ownerMask_s      = NUMBER_OF_CACHES'(oneHot(INDEX_BITS'(busOwner)));
   assign snoopyEligible_s = snoopyRequests & ~ownerMask_s;

   round_robin_select #(
      .WIDTH       (NUMBER_OF_CACHES),
      .INDEX_WIDTH (OWNER_WIDTH)
   ) cpuSelect (
      .requests   (cpuRequests),
      .startIndex (cpuStart_s),
      .found      (cpuFound_s),
      .index      (cpuSelect_s)
   );

   round_robin_select #(
      .WIDTH       (NUMBER_OF_CACHES),
      .INDEX_WIDTH (OWNER_WIDTH)
   ) snoopySelect (
      .requests   (snoopyEligible_s),
      .startIndex ({OWNER_WIDTH{1'b0}}),
      .found      (snoopyFound_s),
      .index      (snoopySelect_s)
   );

   // Arbitration FSM; every output is a register written only here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= IDLE;
         lastOwner_r  <= LAST_CACHE;
         busOwner     <= {OWNER_WIDTH{1'b0}};
         busBusy      <= 1'b0;
         cpuGrants    <= NO_GRANT;
         snoopyGrants <= NO_GRANT;
      end else begin
         case (state_r)
            IDLE: begin
               snoopyGrants <= NO_GRANT;
               if (cpuFound_s) begin
                  state_r   <= GRANTED;
                  busOwner  <= cpuSelect_s;
                  busBusy   <= 1'b1;
                  cpuGrants <= NUMBER_OF_CACHES'(oneHot(INDEX_BITS'(cpuSelect_s)));
               end else begin
                  state_r   <= IDLE;
                  busBusy   <= 1'b0;
                  cpuGrants <= NO_GRANT;
               end
            end

            GRANTED: begin
               if (!cpuRequests[busOwner]) begin
                  // Owner released: both grants drop together, one idle gap follows.
                  state_r      <= IDLE;
                  lastOwner_r  <= busOwner;
                  busBusy      <= 1'b0;
                  cpuGrants    <= NO_GRANT;
                  snoopyGrants <= NO_GRANT;
               end else if (snoopyGrants == NO_GRANT) begin
                  snoopyGrants <= snoopyFound_s
                                  ? NUMBER_OF_CACHES'(oneHot(INDEX_BITS'(snoopySelect_s)))
                                  : NO_GRANT;
               end else if ((snoopyGrants & snoopyRequests) == NO_GRANT) begin
                  // Grantee dropped its request; re-arbitrate only from the next cycle.
                  snoopyGrants <= NO_GRANT;
               end else begin
                  snoopyGrants <= snoopyGrants;
               end
            end

            default: begin
               state_r      <= IDLE;
               lastOwner_r  <= LAST_CACHE;
               busOwner     <= {OWNER_WIDTH{1'b0}};
               busBusy      <= 1'b0;
               cpuGrants    <= NO_GRANT;
               snoopyGrants <= NO_GRANT;
            end
         endcase
      end
   end

endmodule
